// File: rtl/lc4_perf_pkg.sv
// lc4_perf_pkg: counter indices and stall codes shared by the lc4 performance monitor
package lc4_perf_pkg;
   typedef logic [1:0] stall_code_t;
   localparam int PERF_CYCLES  = 0;
   localparam int PERF_EXEC    = 1;
   localparam int PERF_CACHE   = 2;
   localparam int PERF_BRANCH  = 3;
   localparam int PERF_LOAD    = 4;
   localparam int PERF_STORES  = 5;
   localparam int PERF_REGW    = 6;
   localparam int PERF_OVF     = 7;
   localparam int NUM_PERF_CNT = 7;
   localparam stall_code_t STALL_EXEC   = 2'd0;
   localparam stall_code_t STALL_CACHE  = 2'd1;
   localparam stall_code_t STALL_BRANCH = 2'd2;
   localparam stall_code_t STALL_LOAD   = 2'd3;
endpackage

// File: rtl/lc4_perf_counter.sv
// lc4_perf_counter: event counter with sticky overflow flag
// Wraps on overflow, or saturates at all-ones when LC4_PERF_SATURATE_EN is defined.
module lc4_perf_counter #(
   parameter int CNT_W = 32,
   parameter int INC_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [INC_W-1:0] inc,
   output logic [CNT_W-1:0] value,
   output logic [CNT_W-1:0] nxt,
   output logic             ovf,
   output logic             ovf_nxt
);
   logic [CNT_W:0] sum;
   assign sum = {1'b0, value} + (CNT_W+1)'(inc);
`ifdef LC4_PERF_SATURATE_EN
   assign nxt = !en ? value : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
   assign nxt = en ? sum[CNT_W-1:0] : value;
`endif
   assign ovf_nxt = ovf | (en & sum[CNT_W]);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
         ovf   <= 1'b0;
      end else begin
         value <= clr ? '0 : nxt;
         ovf   <= clr ? 1'b0 : ovf_nxt;
      end
   end
endmodule

// File: rtl/lc4_perf_monitor.sv
// lc4_perf_monitor: per-lane cycle/stall/store/regwrite counters with snapshot bank and readout
// Overflow behaviour selected by LC4_PERF_SATURATE_EN (saturate) or its absence (wrap).
module lc4_perf_monitor
   import lc4_perf_pkg::*;
#(
   parameter int LANES = 1,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               gwe,
   input  logic [2*LANES-1:0] stall,
   input  logic [LANES-1:0]   dmem_we,
   input  logic [LANES-1:0]   regfile_we,
   input  logic               clr,
   input  logic               snap_req,
   output logic               snap_done,
   input  logic               rd_en,
   input  logic [2:0]         rd_sel,
   output logic               rd_valid,
   output logic [CNT_W-1:0]   rd_data
);
   localparam int INC_W = $clog2(LANES + 1);
   logic [INC_W-1:0]        inc [NUM_PERF_CNT];
   logic [CNT_W-1:0]        nxt [NUM_PERF_CNT];
   logic [CNT_W-1:0]        live_unused [NUM_PERF_CNT];
   logic [NUM_PERF_CNT-1:0] flag_unused;
   logic [NUM_PERF_CNT-1:0] ovf_nxt;
   logic [CNT_W-1:0]        shadow [NUM_PERF_CNT+1];
   stall_code_t             code;
   // a lane with an unknown stall code is ignored entirely
   always_comb begin
      code = STALL_EXEC;
      for (int k = 0; k < NUM_PERF_CNT; k++) inc[k] = '0;
      inc[PERF_CYCLES] = INC_W'(1);
      for (int i = 0; i < LANES; i++) begin
         code = stall[2*i +: 2];
         if (!$isunknown(code)) begin
            inc[PERF_EXEC]   = inc[PERF_EXEC]   + INC_W'(code == STALL_EXEC);
            inc[PERF_CACHE]  = inc[PERF_CACHE]  + INC_W'(code == STALL_CACHE);
            inc[PERF_BRANCH] = inc[PERF_BRANCH] + INC_W'(code == STALL_BRANCH);
            inc[PERF_LOAD]   = inc[PERF_LOAD]   + INC_W'(code == STALL_LOAD);
            inc[PERF_STORES] = inc[PERF_STORES] + INC_W'(dmem_we[i] & (code == STALL_EXEC));
            inc[PERF_REGW]   = inc[PERF_REGW]   + INC_W'(regfile_we[i] & (code == STALL_EXEC));
         end
      end
   end
   for (genvar k = 0; k < NUM_PERF_CNT; k++) begin : g_cnt
      lc4_perf_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_cnt (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (clr),
         .en      (gwe),
         .inc     (inc[k]),
         .value   (live_unused[k]),
         .nxt     (nxt[k]),
         .ovf     (flag_unused[k]),
         .ovf_nxt (ovf_nxt[k])
      );
   end
   // shadow takes pre-clear next-state; a same-cycle read sees the old shadow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= NUM_PERF_CNT; k++) shadow[k] <= '0;
         snap_done <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         snap_done <= snap_req;
         rd_valid  <= rd_en;
         if (rd_en) rd_data <= shadow[rd_sel];
         if (snap_req) begin
            for (int k = 0; k < NUM_PERF_CNT; k++) shadow[k] <= nxt[k];
            shadow[PERF_OVF] <= CNT_W'(ovf_nxt);
         end
      end
   end
endmodule

// File: tb/tb_lc4_perf_monitor.sv
// tb_lc4_perf_monitor: directed scoreboard bench for scalar, dual-lane and 4-bit monitors
module tb_lc4_perf_monitor;
   logic clk = 1'b0, rst_n = 1'b1, gwe = 1'b0, clr = 1'b0, snap_req = 1'b0, rd_en = 1'b0;
   logic [3:0] stall = '0;
   logic [1:0] dmem_we = '0, regfile_we = '0;
   logic [2:0] rd_sel = '0;
   logic [2:0] rv, sd;
   logic [31:0] a_data, b_data;
   logic [3:0] c_data;
   logic [31:0] rdat [3];
   int tests = 0, fails = 0, cur = 0;
   typedef struct {int inst; int sel; logic [31:0] exp;} exp_t;
   exp_t q[$];
   exp_t e;
`ifdef LC4_PERF_SATURATE_EN
   localparam logic [31:0] OVF_EXP = 32'd15;
`else
   localparam logic [31:0] OVF_EXP = 32'd1;
`endif

   always #5 clk = ~clk;

   lc4_perf_monitor #(.LANES(1), .CNT_W(32)) u_a (
      .clk(clk), .rst_n(rst_n), .gwe(gwe), .stall(stall[1:0]), .dmem_we(dmem_we[0]),
      .regfile_we(regfile_we[0]), .clr(clr), .snap_req(snap_req), .snap_done(sd[0]),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_valid(rv[0]), .rd_data(a_data));
   lc4_perf_monitor #(.LANES(2), .CNT_W(32)) u_b (
      .clk(clk), .rst_n(rst_n), .gwe(gwe), .stall(stall), .dmem_we(dmem_we),
      .regfile_we(regfile_we), .clr(clr), .snap_req(snap_req), .snap_done(sd[1]),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_valid(rv[1]), .rd_data(b_data));
   lc4_perf_monitor #(.LANES(1), .CNT_W(4)) u_c (
      .clk(clk), .rst_n(rst_n), .gwe(gwe), .stall(stall[1:0]), .dmem_we(dmem_we[0]),
      .regfile_we(regfile_we[0]), .clr(clr), .snap_req(snap_req), .snap_done(sd[2]),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_valid(rv[2]), .rd_data(c_data));

   assign rdat[0] = a_data;
   assign rdat[1] = b_data;
   assign rdat[2] = {28'd0, c_data};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0d required=%0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      {gwe, clr, snap_req, rd_en} = '0;
      stall = '0; dmem_we = '0; regfile_we = '0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run(input int n, input logic g, input logic [3:0] s,
                      input logic [1:0] dw, input logic [1:0] rw);
      for (int i = 0; i < n; i++) begin
         gwe = g; stall = s; dmem_we = dw; regfile_we = rw;
         @(negedge clk);
      end
      gwe = 1'b0; stall = '0; dmem_we = '0; regfile_we = '0;
   endtask

   task automatic snap();
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      check("snap_done", sd[0], 1);
      @(negedge clk);
      check("snap_done_fall", sd[0], 0);
   endtask

   // response is popped from the scoreboard in the cycle the DUT presents it
   task automatic collect();
      check("rd_valid", rv[cur], 1);
      if (q.size() > 0 && rv[cur]) begin
         e = q.pop_front();
         check($sformatf("rd_u%0d_idx%0d", e.inst, e.sel), rdat[e.inst], e.exp);
      end
   endtask

   task automatic rd(input int inst, input int sel, input logic [31:0] exp);
      cur = inst;
      rd_en = 1'b1;
      rd_sel = 3'(sel);
      q.push_back('{inst, sel, exp});
      @(negedge clk);
      rd_en = 1'b0;
      collect();
   endtask

   initial begin
      do_reset();
      check("rst_rd_valid", rv[0], 0);
      check("rst_rd_data", a_data, 0);
      check("rst_snap_done", sd[0], 0);
      rd(0, 0, 0);
      // 10 exec cycles
      run(10, 1, 4'd0, 2'd0, 2'd0);
      snap();
      rd(0, 0, 10);
      rd(0, 1, 10);
      for (int s = 2; s < 5; s++) rd(0, s, 0);
      rd(0, 7, 0);
      // stall code sequence 0,1,2,3,3
      do_reset();
      run(1, 1, 4'd0, 2'd0, 2'd0);
      run(1, 1, 4'd1, 2'd0, 2'd0);
      run(1, 1, 4'd2, 2'd0, 2'd0);
      run(2, 1, 4'd3, 2'd0, 2'd0);
      snap();
      rd(0, 0, 5); rd(0, 1, 1); rd(0, 2, 1); rd(0, 3, 1); rd(0, 4, 2);
      // gwe gating
      do_reset();
      run(1, 1, 4'd0, 2'd0, 2'd0);
      run(1, 0, 4'd0, 2'd0, 2'd0);
      run(1, 1, 4'd0, 2'd0, 2'd0);
      run(1, 0, 4'd0, 2'd0, 2'd0);
      snap();
      rd(0, 0, 2); rd(0, 1, 2);
      // dual lane: lane0 exec with store, lane1 load; lane1 regfile_we must not count
      do_reset();
      run(4, 1, 4'b1100, 2'b01, 2'b11);
      snap();
      rd(1, 0, 4); rd(1, 1, 4); rd(1, 4, 4); rd(1, 5, 4); rd(1, 6, 4); rd(1, 3, 0);
      // 4-bit counters overflow after 16 increments
      do_reset();
      run(17, 1, 4'd0, 2'd0, 2'd0);
      snap();
      rd(2, 1, OVF_EXP); rd(2, 0, OVF_EXP); rd(2, 7, 3); rd(2, 2, 0);
      rd(0, 1, 17);
      // clear with snapshot, then clear beating increment
      do_reset();
      run(7, 1, 4'd0, 2'd0, 2'd0);
      clr = 1'b1; snap_req = 1'b1;
      @(negedge clk);
      clr = 1'b0; snap_req = 1'b0;
      check("clr_snap_done", sd[0], 1);
      rd(0, 0, 7);
      clr = 1'b1; gwe = 1'b1;
      @(negedge clk);
      clr = 1'b0; gwe = 1'b0;
      snap();
      rd(0, 0, 0); rd(0, 1, 0);
      // read in the snapshot cycle returns the older shadow
      run(3, 1, 4'd0, 2'd0, 2'd0);
      cur = 0; rd_en = 1'b1; rd_sel = 3'd0; snap_req = 1'b1;
      q.push_back('{0, 0, 32'd0});
      @(negedge clk);
      rd_en = 1'b0; snap_req = 1'b0;
      collect();
      rd(0, 0, 3);
      // asynchronous reset while a read response is being presented
      rd(0, 0, 3);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_rd_valid", rv[0], 0);
      check("async_rst_rd_data", a_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rd(0, 0, 0);
      check("sb_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lc4_perf_monitor.md
# lc4_perf_monitor

Synthesizable performance monitor that replaces bench-side cycle/stall bookkeeping with on-chip counters. Sits beside `lc4_processor` and watches the per-lane `test_stall`, `test_dmem_we` and `test_regfile_we` outputs, qualified by `gwe` from `lc4_we_gen`. It counts cycles, committed instructions, stall cycles by cause, stores and register writes for 1..N commit lanes. It also provides an atomic snapshot and a registered readout port for software or a bench.

## Interface
- `LANES`, default 1: commit lanes observed (1 = scalar, 2 = superscalar).
- `CNT_W`, default 32: width of every counter and of `rd_data`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `gwe`  in  1  global write enable; counters advance only when 1.
- `stall`  in  2*LANES  per-lane `test_stall` code; lane i is bits [2i+1:2i]. Codes: 0 = exec, 1 = cache, 2 = branch, 3 = load.
- `dmem_we`  in  LANES  per-lane `test_dmem_we`.
- `regfile_we`  in  LANES  per-lane `test_regfile_we`.
- `clr`  in  1  synchronous clear of live counters and overflow flags.
- `snap_req`  in  1  capture all live counters into shadow registers.
- `snap_done`  out  1  one-cycle pulse, cycle after capture.
- `rd_en`  in  1  read request.
- `rd_sel`  in  3  counter index.
- `rd_valid`  out  1  `rd_data` valid.
- `rd_data`  out  CNT_W  shadow counter value.

## Operation
- Counter indices: 0 cycles, 1 exec, 2 cache_stall, 3 branch_stall, 4 load_stall, 5 stores, 6 reg_writes, 7 overflow flags (bits [6:0], zero-extended).
- Each `gwe`=1 cycle:
  - cycles += 1.
  - For every lane, the counter matching its stall code += 1. Increments are summed across lanes; the adder is clog2(LANES+1) bits wide.
  - For every lane with code 0: stores += `dmem_we`, reg_writes += `regfile_we`.
- A lane whose stall code contains X/Z contributes nothing.
- `gwe`=0: no counter changes, including cycles.
- Overflow: a counter whose next value exceeds 2^CNT_W−1 sets its sticky flag in index 7. The value then wraps or saturates according to Configuration.
- `clr`: live counters and flags become 0 next edge. Clear beats increment in the same cycle: the result is 0, not 1.
- `snap_req`: shadow[k] ← live next-state[k], i.e. this cycle's increment is included. `snap_done` pulses the following cycle.
- `snap_req` and `clr` together: the shadow gets the pre-clear next-state; live becomes 0.
- Readout always returns shadow values, never live ones.
- Reset: all live counters, shadows and flags = 0; `snap_done`=0; `rd_valid`=0; `rd_data`=0.
- Reset asserted mid-operation clears everything immediately and asynchronously. A pending read or snapshot is dropped.

## Timing
- Live counter update: 1 cycle after the qualifying edge.
- Shadow capture: same edge as the live update. `snap_done` is high during cycle N+1 for `snap_req` in cycle N.
- Read: `rd_en` in cycle N gives `rd_valid`=1 and `rd_data`=shadow[`rd_sel`] in cycle N+1. `rd_valid` is 0 otherwise, and `rd_data` holds its last value.
- Back-to-back reads are allowed every cycle; there is no backpressure.
- Read and snapshot in the same cycle N: the read returns the pre-capture shadow.

## Configuration
- `LC4_PERF_SATURATE_EN` defined: a counter that overflows sticks at all-ones until `clr` or reset.
- Undefined: a counter that overflows wraps modulo 2^CNT_W.
- In both modes the overflow flag sets and stays set.

## Structure
- Package `lc4_perf_pkg`:
  - counter index localparams (`PERF_CYCLES` … `PERF_OVF`),
  - stall code constants (`STALL_EXEC`, `STALL_CACHE`, `STALL_BRANCH`, `STALL_LOAD`),
  - `NUM_PERF_CNT` = 7.
- Sub-module `lc4_perf_counter`:
  - parameters `CNT_W` and `INC_W`,
  - inputs: increment, `clr`, `en`,
  - outputs: value, next-state, overflow flag,
  - holds the saturate/wrap logic.
- Top level instantiates seven counters plus the per-lane decode, shadow bank and read mux.

## Test plan
- Reset, then 10 cycles with `gwe`=1, `LANES`=1, stall=0, snap, read idx 0 and 1 -> both read 10; idx 2–4 read 0.
- Lane stall sequence 0,1,2,3,3 with `gwe` high, then snap -> cycles=5, exec=1, cache=1, branch=1, load=2.
- `gwe` toggling 1,0,1,0 over 4 cycles with stall=0 -> cycles=2, exec=2.
- `LANES`=2, lane0=0 with `dmem_we`=1, lane1=3, 4 cycles -> exec=4, load=4, stores=4, cycles=4.
- `CNT_W`=4, 17 exec cycles:
  - with `LC4_PERF_SATURATE_EN` -> exec=15, flag bit1=1;
  - without it -> exec=1, flag bit1=1.
- `clr` and `snap_req` in the same cycle after 7 cycles -> shadow cycles=7; the next snap reads 0. `rst_n` low during a read -> `rd_valid` falls to 0 immediately.
